// File: rtl/jtag_tap_multi_dr.sv
// JTAG TAP controller with BYPASS, IDCODE and N_USER user data-register channels.
// All state advances on the rising edge of TCK (clk); TDO is launched on the
// falling edge so the host can sample it on the following rising edge.
module jtag_tap_multi_dr #(
  parameter int          IR_WIDTH = 4,
  parameter int          N_USER   = 2,
  parameter int          DR_WIDTH = 8,
  parameter logic [31:0] IDCODE   = 32'h4A7A6001
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         tms,
  input  logic                         tdi,
  output logic                         tdo,
  output logic                         tdo_en,
  output logic [3:0]                   tap_state,
  output logic [IR_WIDTH-1:0]          ir_q,
  input  logic [N_USER*DR_WIDTH-1:0]   dr_capture_data,
  output logic [N_USER*DR_WIDTH-1:0]   dr_update_data,
  output logic [N_USER-1:0]            dr_update_pulse
);

  typedef enum logic [3:0] {
    TLR      = 4'hF,
    RTI      = 4'hC,
    SEL_DR   = 4'h7,
    CAP_DR   = 4'h6,
    SH_DR    = 4'h2,
    EX1_DR   = 4'h1,
    PAUSE_DR = 4'h3,
    EX2_DR   = 4'h0,
    UPD_DR   = 4'h5,
    SEL_IR   = 4'h4,
    CAP_IR   = 4'hE,
    SH_IR    = 4'hA,
    EX1_IR   = 4'h9,
    PAUSE_IR = 4'hB,
    EX2_IR   = 4'h8,
    UPD_IR   = 4'hD
  } tap_state_e;

  localparam logic [IR_WIDTH-1:0] INSTR_IDCODE   = IR_WIDTH'(1);
  localparam logic [IR_WIDTH-1:0] INSTR_USER0    = IR_WIDTH'(2);
  localparam logic [IR_WIDTH-1:0] INSTR_USER_END = IR_WIDTH'(N_USER + 2);
  localparam logic [IR_WIDTH-1:0] IR_CAPTURE     = IR_WIDTH'(1);
  localparam int                  IDX_W          = (N_USER > 1) ? $clog2(N_USER) : 1;
  localparam logic [31:0]         IDCODE_VAL     = {IDCODE[31:1], 1'b1};

  tap_state_e           state_q;
  logic [IR_WIDTH-1:0]  ir_shift;
  logic                 bypass_q;
  logic [31:0]          idcode_shift;
  logic [DR_WIDTH-1:0]  user_shift;

  logic                 sel_idcode;
  logic                 sel_user;
  logic [IDX_W-1:0]     user_idx;

  assign tap_state = state_q;

  // TAP state machine: standard 1149.1 transitions sampled on tms.
  // NOTE: every sequential block uses non-blocking assignments so all
  // registers see pre-edge values of each other, matching real flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= TLR;
    end else begin
      case (state_q)
        TLR:      state_q <= tms ? TLR    : RTI;
        RTI:      state_q <= tms ? SEL_DR : RTI;
        SEL_DR:   state_q <= tms ? SEL_IR : CAP_DR;
        CAP_DR:   state_q <= tms ? EX1_DR : SH_DR;
        SH_DR:    state_q <= tms ? EX1_DR : SH_DR;
        EX1_DR:   state_q <= tms ? UPD_DR : PAUSE_DR;
        PAUSE_DR: state_q <= tms ? EX2_DR : PAUSE_DR;
        EX2_DR:   state_q <= tms ? UPD_DR : SH_DR;
        UPD_DR:   state_q <= tms ? SEL_DR : RTI;
        SEL_IR:   state_q <= tms ? TLR    : CAP_IR;
        CAP_IR:   state_q <= tms ? EX1_IR : SH_IR;
        SH_IR:    state_q <= tms ? EX1_IR : SH_IR;
        EX1_IR:   state_q <= tms ? UPD_IR : PAUSE_IR;
        PAUSE_IR: state_q <= tms ? EX2_IR : PAUSE_IR;
        EX2_IR:   state_q <= tms ? UPD_IR : SH_IR;
        UPD_IR:   state_q <= tms ? SEL_DR : RTI;
        default:  state_q <= TLR;
      endcase
    end
  end

  // Instruction decode: IDCODE, USER k, everything else falls back to BYPASS.
  // NOTE: every output gets a default before any condition so no latch is inferred.
  always_comb begin
    sel_idcode = 1'b0;
    sel_user   = 1'b0;
    user_idx   = '0;
    if (ir_q == INSTR_IDCODE) begin
      sel_idcode = 1'b1;
    end else if (ir_q >= INSTR_USER0 && ir_q < INSTR_USER_END) begin
      sel_user = 1'b1;
      user_idx = IDX_W'(ir_q - INSTR_USER0);
    end
  end

  // Instruction register: capture the fixed 01 pattern, shift LSB first,
  // commit in Update-IR; Test-Logic-Reset forces IDCODE every cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ir_shift <= '0;
      ir_q     <= INSTR_IDCODE;
    end else begin
      case (state_q)
        CAP_IR:  ir_shift <= IR_CAPTURE;
        SH_IR:   ir_shift <= IR_WIDTH'({tdi, ir_shift} >> 1);
        UPD_IR:  ir_q     <= ir_shift;
        TLR:     ir_q     <= INSTR_IDCODE;
        default: ;
      endcase
    end
  end

  // Data registers: only the register chosen by ir_q captures and shifts.
  // Pause states fall through untouched, so shifting resumes where it left off.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bypass_q     <= 1'b0;
      idcode_shift <= '0;
      user_shift   <= '0;
    end else if (state_q == CAP_DR) begin
      if (sel_user)        user_shift   <= dr_capture_data[int'(user_idx)*DR_WIDTH +: DR_WIDTH];
      else if (sel_idcode) idcode_shift <= IDCODE_VAL;
      else                 bypass_q     <= 1'b0;
    end else if (state_q == SH_DR) begin
      if (sel_user)        user_shift   <= DR_WIDTH'({tdi, user_shift} >> 1);
      else if (sel_idcode) idcode_shift <= {tdi, idcode_shift[31:1]};
      else                 bypass_q     <= tdi;
    end
  end

  // User update: latch the shifted value into the selected channel and strobe
  // its pulse for one cycle; the latched values survive Test-Logic-Reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dr_update_data  <= '0;
      dr_update_pulse <= '0;
    end else begin
      dr_update_pulse <= '0;
      if (state_q == UPD_DR && sel_user) begin
        dr_update_data[int'(user_idx)*DR_WIDTH +: DR_WIDTH] <= user_shift;
        dr_update_pulse[user_idx]                           <= 1'b1;
      end
    end
  end

  // TDO launch on the falling edge: LSB of the active shift path while shifting.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tdo    <= 1'b0;
      tdo_en <= 1'b0;
    end else begin
      tdo    <= 1'b0;
      tdo_en <= 1'b0;
      if (state_q == SH_IR) begin
        tdo    <= ir_shift[0];
        tdo_en <= 1'b1;
      end else if (state_q == SH_DR) begin
        tdo_en <= 1'b1;
        if (sel_user)        tdo <= user_shift[0];
        else if (sel_idcode) tdo <= idcode_shift[0];
        else                 tdo <= bypass_q;
      end
    end
  end

endmodule

// File: tb/tb_jtag_tap_multi_dr.sv
// Self-checking bench for jtag_tap_multi_dr: directed scenarios plus randomized
// IR/DR scans and TMS walks checked against a transaction-level model.
module tb_jtag_tap_multi_dr;

  localparam int          IR_W   = 4;
  localparam int          N_USER = 2;
  localparam int          DR_W   = 8;
  localparam logic [31:0] IDC    = 32'h4A7A6001;

  logic                     clk;
  logic                     rst_n;
  logic                     tms;
  logic                     tdi;
  logic                     tdo;
  logic                     tdo_en;
  logic [3:0]               tap_state;
  logic [IR_W-1:0]          ir_q;
  logic [N_USER*DR_W-1:0]   dr_capture_data;
  logic [N_USER*DR_W-1:0]   dr_update_data;
  logic [N_USER-1:0]        dr_update_pulse;

  jtag_tap_multi_dr #(
    .IR_WIDTH (IR_W),
    .N_USER   (N_USER),
    .DR_WIDTH (DR_W),
    .IDCODE   (IDC)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .tms             (tms),
    .tdi             (tdi),
    .tdo             (tdo),
    .tdo_en          (tdo_en),
    .tap_state       (tap_state),
    .ir_q            (ir_q),
    .dr_capture_data (dr_capture_data),
    .dr_update_data  (dr_update_data),
    .dr_update_pulse (dr_update_pulse)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;

  // Reference TAP diagram as two lookup tables: next state for tms=0 / tms=1.
  logic [3:0] nxt0 [16];
  logic [3:0] nxt1 [16];

  logic [N_USER*DR_W-1:0] exp_upd;
  logic                   s_tdo;
  logic                   s_tdo_en;

  // One TCK: sample TDO (launched on the falling edge), drive pins, then
  // let the rising edge act; returns 1 time unit after the rising edge.
  task automatic step(input logic t, input logic d);
    @(negedge clk);
    #1;
    s_tdo    = tdo;
    s_tdo_en = tdo_en;
    tms      = t;
    tdi      = d;
    @(posedge clk);
    #1;
  endtask

  // IR scan starting and ending in Run-Test/Idle; returns the bits seen on TDO.
  task automatic scan_ir(input logic [IR_W-1:0] val, output logic [IR_W-1:0] cap);
    cap = '0;
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    for (int i = 0; i < IR_W; i++) begin
      step(i == IR_W - 1, val[i]);
      cap[i] = s_tdo;
    end
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
  endtask

  // DR scan of len bits from Run-Test/Idle with an optional pause after bit
  // pause_at; returns TDO bits and the pulse vector seen after Update-DR.
  task automatic scan_dr(input int len, input logic [31:0] din, input int pause_at,
                         output logic [31:0] dout, output logic [N_USER-1:0] pulse);
    int en_bad;
    en_bad = 0;
    dout   = '0;
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    for (int i = 0; i < len; i++) begin
      step((i == len - 1) || (i == pause_at), din[i]);
      dout[i] = s_tdo;
      if (s_tdo_en !== 1'b1) en_bad++;
      if (i == pause_at && i != len - 1) begin
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
      end
    end
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    pulse = dr_update_pulse;
    step(1'b0, 1'b0);
    checks++;
    if (en_bad != 0 || dr_update_pulse !== '0) begin
      errors++;
      $display("FAIL scan_dr_en_pulse: tdo_en low count %0d, pulse after one cycle %b, required 0 and 0",
               en_bad, dr_update_pulse);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tms   = 1'b1;
    tdi   = 1'b0;
    #12;
    checks++;
    if (tap_state !== 4'hF || ir_q !== IR_W'(1) || dr_update_data !== '0 ||
        dr_update_pulse !== '0 || tdo !== 1'b0 || tdo_en !== 1'b0) begin
      errors++;
      $display("FAIL reset: state %h ir %h upd %h pulse %b tdo %b en %b, required F 1 0 0 0 0",
               tap_state, ir_q, dr_update_data, dr_update_pulse, tdo, tdo_en);
    end
    #2;
    rst_n   = 1'b1;
    exp_upd = '0;
  endtask

  task automatic test_idcode();
    logic [31:0] got;
    int          en_bad;
    got    = '0;
    en_bad = 0;
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    for (int i = 0; i < 32; i++) begin
      step(1'b0, 1'b0);
      got[i] = s_tdo;
      if (s_tdo_en !== 1'b1) en_bad++;
    end
    checks++;
    if (got !== (IDC | 32'h1)) begin
      errors++;
      $display("FAIL idcode_shift: got %h required %h", got, IDC | 32'h1);
    end
    checks++;
    if (en_bad != 0 || ir_q !== IR_W'(1) || tap_state !== 4'h2) begin
      errors++;
      $display("FAIL idcode_status: en low %0d ir %h state %h, required 0 1 2", en_bad, ir_q, tap_state);
    end
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
    @(negedge clk);
    #1;
    checks++;
    if (tap_state !== 4'hF || ir_q !== IR_W'(1) || tdo_en !== 1'b0) begin
      errors++;
      $display("FAIL tms5_to_tlr: state %h ir %h en %b, required F 1 0", tap_state, ir_q, tdo_en);
    end
  endtask

  task automatic test_bypass();
    logic [IR_W-1:0]   cap;
    logic [31:0]       dout;
    logic [N_USER-1:0] pulse;
    step(1'b0, 1'b0);
    scan_ir(IR_W'(4'hF), cap);
    checks++;
    if (cap !== IR_W'(1) || ir_q !== IR_W'(4'hF)) begin
      errors++;
      $display("FAIL bypass_ir: captured %b ir %h, required 0001 F", cap, ir_q);
    end
    scan_dr(4, 32'b1101, -1, dout, pulse);
    checks++;
    if (dout[3:0] !== 4'b1010 || pulse !== '0 || dr_update_data !== exp_upd) begin
      errors++;
      $display("FAIL bypass_dr: tdo %b pulse %b upd %h, required 1010 0 %h",
               dout[3:0], pulse, dr_update_data, exp_upd);
    end
  endtask

  task automatic test_user();
    logic [IR_W-1:0]   cap;
    logic [31:0]       dout;
    logic [N_USER-1:0] pulse;
    dr_capture_data = {8'hA5, 8'h3C};
    scan_ir(IR_W'(3), cap);
    checks++;
    if (ir_q !== IR_W'(3)) begin
      errors++;
      $display("FAIL user_ir: ir %h required 3", ir_q);
    end
    scan_dr(DR_W, 32'h96, -1, dout, pulse);
    exp_upd[15:8] = 8'h96;
    checks++;
    if (dout[7:0] !== 8'hA5 || pulse !== 2'b10 || dr_update_data !== exp_upd) begin
      errors++;
      $display("FAIL user1_scan: tdo %h pulse %b upd %h, required A5 10 %h",
               dout[7:0], pulse, dr_update_data, exp_upd);
    end
    // Capture -> Exit1 -> Update with no shifts commits the captured value.
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    exp_upd[15:8] = 8'hA5;
    checks++;
    if (dr_update_pulse !== 2'b10 || dr_update_data !== exp_upd) begin
      errors++;
      $display("FAIL user1_zero_shift: pulse %b upd %h, required 10 %h",
               dr_update_pulse, dr_update_data, exp_upd);
    end
    step(1'b0, 1'b0);
    checks++;
    if (dr_update_pulse !== '0) begin
      errors++;
      $display("FAIL user1_pulse_width: pulse %b required 00", dr_update_pulse);
    end
  endtask

  task automatic test_undefined();
    logic [IR_W-1:0]   cap;
    logic [31:0]       dout;
    logic [31:0]       din;
    logic [N_USER-1:0] pulse;
    scan_ir(IR_W'(0), cap);
    din = $urandom;
    scan_dr(6, din, 2, dout, pulse);
    checks++;
    if (ir_q !== IR_W'(0) || dout[5:0] !== 6'((din << 1) & 32'h3F) || pulse !== '0 ||
        dr_update_data !== exp_upd) begin
      errors++;
      $display("FAIL undefined_ir: ir %h tdo %b pulse %b upd %h, required 0 %b 0 %h",
               ir_q, dout[5:0], pulse, dr_update_data, 6'((din << 1) & 32'h3F), exp_upd);
    end
  endtask

  task automatic test_random_scans();
    logic [IR_W-1:0]   instr;
    logic [IR_W-1:0]   cap;
    logic [31:0]       din;
    logic [31:0]       dout;
    logic [31:0]       want;
    logic [31:0]       mask;
    logic [N_USER-1:0] pulse;
    logic [N_USER-1:0] want_pulse;
    int                len;
    int                pause_at;
    int                k;
    for (int it = 0; it < 24; it++) begin
      instr           = IR_W'($urandom_range(0, (1 << IR_W) - 1));
      dr_capture_data = (N_USER*DR_W)'($urandom);
      din             = $urandom;
      scan_ir(instr, cap);
      checks++;
      if (cap !== IR_W'(1) || ir_q !== instr) begin
        errors++;
        $display("FAIL rand_ir[%0d]: captured %b ir %h, required 0001 %h", it, cap, ir_q, instr);
      end
      want_pulse = '0;
      if (instr == 1) begin
        len  = 32;
        want = IDC | 32'h1;
      end else if (instr >= 2 && instr < N_USER + 2) begin
        k    = int'(instr) - 2;
        len  = DR_W;
        want = 32'(dr_capture_data[k*DR_W +: DR_W]);
        want_pulse[k] = 1'b1;
        exp_upd[k*DR_W +: DR_W] = din[DR_W-1:0];
      end else begin
        len  = $urandom_range(1, 8);
        want = din << 1;
      end
      mask     = (len == 32) ? 32'hFFFF_FFFF : ((32'h1 << len) - 1);
      pause_at = $urandom_range(0, len) == len ? -1 : $urandom_range(0, len - 1);
      scan_dr(len, din, pause_at, dout, pulse);
      checks++;
      if ((dout & mask) !== (want & mask) || pulse !== want_pulse || dr_update_data !== exp_upd) begin
        errors++;
        $display("FAIL rand_dr[%0d] ir %h len %0d: tdo %h pulse %b upd %h, required %h %b %h",
                 it, instr, len, dout & mask, pulse, dr_update_data, want & mask, want_pulse, exp_upd);
      end
    end
  endtask

  task automatic test_tms_walk();
    logic [IR_W-1:0] cap;
    logic [3:0]      s;
    logic [3:0]      prev;
    logic            t;
    int              bad;
    scan_ir(IR_W'(4'hF), cap);
    s   = 4'hC;
    bad = 0;
    for (int i = 0; i < 150; i++) begin
      t    = 1'($urandom_range(0, 1));
      prev = s;
      step(t, 1'b0);
      s = t ? nxt1[prev] : nxt0[prev];
      checks++;
      if (tap_state !== s || s_tdo_en !== (prev == 4'h2 || prev == 4'hA) || dr_update_pulse !== '0) begin
        errors++;
        bad++;
        if (bad < 5)
          $display("FAIL tms_walk[%0d]: state %h en %b pulse %b, required %h %b 0",
                   i, tap_state, s_tdo_en, dr_update_pulse, s, (prev == 4'h2 || prev == 4'hA));
      end
    end
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
    checks++;
    if (tap_state !== 4'hF || ir_q !== IR_W'(1) || dr_update_data !== exp_upd) begin
      errors++;
      $display("FAIL walk_exit: state %h ir %h upd %h, required F 1 %h (TLR keeps update data)",
               tap_state, ir_q, dr_update_data, exp_upd);
    end
    step(1'b0, 1'b0);
  endtask

  task automatic test_reset_mid_shift();
    logic [IR_W-1:0] cap;
    dr_capture_data = {8'h00, 8'hFF};
    scan_ir(IR_W'(2), cap);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    exp_upd = '0;
    checks++;
    if (tap_state !== 4'hF || ir_q !== IR_W'(1) || dr_update_data !== '0 ||
        dr_update_pulse !== '0 || tdo !== 1'b0 || tdo_en !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_shift: state %h ir %h upd %h pulse %b tdo %b en %b, required F 1 0 0 0 0",
               tap_state, ir_q, dr_update_data, dr_update_pulse, tdo, tdo_en);
    end
    tms = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (tap_state !== 4'hF || dr_update_pulse !== '0) begin
      errors++;
      $display("FAIL reset_hold: state %h pulse %b, required F 00", tap_state, dr_update_pulse);
    end
    @(negedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    nxt0[4'hF] = 4'hC; nxt1[4'hF] = 4'hF;
    nxt0[4'hC] = 4'hC; nxt1[4'hC] = 4'h7;
    nxt0[4'h7] = 4'h6; nxt1[4'h7] = 4'h4;
    nxt0[4'h6] = 4'h2; nxt1[4'h6] = 4'h1;
    nxt0[4'h2] = 4'h2; nxt1[4'h2] = 4'h1;
    nxt0[4'h1] = 4'h3; nxt1[4'h1] = 4'h5;
    nxt0[4'h3] = 4'h3; nxt1[4'h3] = 4'h0;
    nxt0[4'h0] = 4'h2; nxt1[4'h0] = 4'h5;
    nxt0[4'h5] = 4'hC; nxt1[4'h5] = 4'h7;
    nxt0[4'h4] = 4'hE; nxt1[4'h4] = 4'hF;
    nxt0[4'hE] = 4'hA; nxt1[4'hE] = 4'h9;
    nxt0[4'hA] = 4'hA; nxt1[4'hA] = 4'h9;
    nxt0[4'h9] = 4'hB; nxt1[4'h9] = 4'hD;
    nxt0[4'hB] = 4'hB; nxt1[4'hB] = 4'h8;
    nxt0[4'h8] = 4'hA; nxt1[4'h8] = 4'hD;
    nxt0[4'hD] = 4'hC; nxt1[4'hD] = 4'h7;

    dr_capture_data = '0;
    exp_upd         = '0;
    test_reset();
    test_idcode();
    test_bypass();
    test_user();
    test_undefined();
    test_random_scans();
    test_tms_walk();
    test_reset_mid_shift();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
